// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program-load imem, PC, IF/ID register and IDLE/RUN/HALT control.
// Define IF_BRANCH_FLUSH_EN to flush IF/ID on a taken branch; otherwise the slot is a delay slot.
module instruction_fetch #(
  parameter int IMEM_DEPTH_LOG2 = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       imem_we,
  input  logic [IMEM_DEPTH_LOG2-1:0] imem_waddr,
  input  logic [31:0]                imem_wdata,
  input  logic                       run,
  input  logic                       stall,
  input  logic                       branch_s3,
  input  logic [31:0]                branch_target_s3,
  output logic [31:0]                instruction_s1,
  output logic [31:0]                pc_out1_s1,
  output logic                       busy,
  output logic                       halted
);

  localparam int          DEPTH  = 1 << IMEM_DEPTH_LOG2;
  localparam logic [31:0] BUBBLE = 32'h0800_0000;
  localparam logic [5:0]  OP_HLT = 6'b111111;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic [31:0] imem_q [DEPTH];

  logic [IMEM_DEPTH_LOG2-1:0] idx;
  logic [31:0]                fetch_word;
  logic [31:0]                pc_plus4;
  logic [31:0]                tgt;
  logic                       unused_tgt;

  assign idx        = pc_q[IMEM_DEPTH_LOG2+1:2];
  assign fetch_word = imem_q[idx];
  assign pc_plus4   = pc_q + 32'd4;
  assign tgt        = {branch_target_s3[31:2], 2'b00};
  assign unused_tgt = ^branch_target_s3[1:0];

  // Program memory is writable only while idle and survives reset.
  always_ff @(posedge clk) begin
    if (!reset && state_q == IDLE && imem_we)
      imem_q[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= BUBBLE;
      pc4_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          instr_q <= BUBBLE;
          if (run) begin
            state_q <= RUN;
            pc_q    <= '0;
          end
        end
        RUN: begin
          if (branch_s3) begin
            pc_q <= tgt;
`ifdef IF_BRANCH_FLUSH_EN
            instr_q <= BUBBLE;
            pc4_q   <= tgt;
`else
            instr_q <= fetch_word;
            pc4_q   <= pc_plus4;
`endif
          end else if (!stall) begin
            if (fetch_word[31:26] == OP_HLT) begin
              // pc stays on the halt word
              state_q <= HALT;
              instr_q <= BUBBLE;
            end else begin
              instr_q <= fetch_word;
              pc4_q   <= pc_plus4;
              pc_q    <= pc_plus4;
            end
          end
        end
        HALT: begin
          if (!run) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instruction_s1 = instr_q;
  assign pc_out1_s1     = pc4_q;
  assign busy           = (state_q == RUN);
  assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load/run, stall, branch, halt, reset, PC wrap.
module tb_instruction_fetch;

  localparam int          L      = 6;
  localparam logic [31:0] BUBBLE = 32'h0800_0000;
  localparam logic [31:0] WA = 32'h1111_0001, WB = 32'h2222_0002, WC = 32'h3333_0003,
                          WD = 32'h4444_0004, WE = 32'h5555_0005, WF = 32'h6666_0006;

  logic          clk = 1'b0;
  logic          reset, imem_we, run, stall, branch_s3;
  logic [L-1:0]  imem_waddr;
  logic [31:0]   imem_wdata, branch_target_s3;
  logic [31:0]   instruction_s1, pc_out1_s1;
  logic          busy, halted;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch #(.IMEM_DEPTH_LOG2(L)) dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .run(run), .stall(stall), .branch_s3(branch_s3),
    .branch_target_s3(branch_target_s3), .instruction_s1(instruction_s1),
    .pc_out1_s1(pc_out1_s1), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = L'(a); imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                        input logic b, input logic h);
    chk({tag, ".instr"}, instruction_s1, ins);
    chk({tag, ".pc4"}, pc_out1_s1, p4);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
  endtask

  initial begin
    reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    run = 1'b0; stall = 1'b0; branch_s3 = 1'b0; branch_target_s3 = '0;
    tick();
    chk_if("reset", BUBBLE, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;

    wr(0, WA); wr(1, WB); wr(2, WC); wr(3, WD); wr(4, WE); wr(5, WF);
    chk_if("idle", BUBBLE, 32'd0, 1'b0, 1'b0);

    // start, then A,B with stall on B, then C,D
    run = 1'b1; tick(); run = 1'b0;
    chk_if("start", BUBBLE, 32'd0, 1'b1, 1'b0);
    tick(); chk_if("A", WA, 32'd4, 1'b1, 1'b0);
    tick(); chk_if("B", WB, 32'd8, 1'b1, 1'b0);
    stall = 1'b1;
    tick(); chk_if("stall1", WB, 32'd8, 1'b1, 1'b0);
    tick(); chk_if("stall2", WB, 32'd8, 1'b1, 1'b0);
    stall = 1'b0;
    tick(); chk_if("C", WC, 32'd12, 1'b1, 1'b0);
    tick(); chk_if("D", WD, 32'd16, 1'b1, 1'b0);

    // branch with stall, pc=16 -> target 0x12 aligned to 0x10
    branch_s3 = 1'b1; stall = 1'b1; branch_target_s3 = 32'h0000_0012;
    tick();
`ifdef IF_BRANCH_FLUSH_EN
    chk_if("br.slot", BUBBLE, 32'h10, 1'b1, 1'b0);
`else
    chk_if("br.slot", WE, 32'd20, 1'b1, 1'b0);
`endif
    branch_s3 = 1'b0; stall = 1'b0;
    tick(); chk_if("br.tgt", WE, 32'h14, 1'b1, 1'b0);

    // branch past the memory end wraps the fetch index
    branch_s3 = 1'b1; branch_target_s3 = 32'h0000_0100;
    tick();
`ifdef IF_BRANCH_FLUSH_EN
    chk_if("wrap.slot", BUBBLE, 32'h100, 1'b1, 1'b0);
`else
    chk_if("wrap.slot", WF, 32'h18, 1'b1, 1'b0);
`endif
    branch_s3 = 1'b0;
    tick(); chk_if("wrap", WA, 32'h104, 1'b1, 1'b0);

    // reset mid-run with concurrent branch
    reset = 1'b1; branch_s3 = 1'b1; branch_target_s3 = 32'h0000_0040;
    tick(); chk_if("rst.run", BUBBLE, 32'd0, 1'b0, 1'b0);
    reset = 1'b0; branch_s3 = 1'b0;

    // halt word at imem[2]; write attempt during RUN must be ignored
    wr(2, 32'hFC00_0000);
    run = 1'b1; tick(); run = 1'b0;
    imem_we = 1'b1; imem_waddr = L'(1); imem_wdata = 32'hDEAD_BEEF;
    tick(); chk_if("rerun.A", WA, 32'd4, 1'b1, 1'b0);
    imem_we = 1'b0;
    tick(); chk_if("rerun.B", WB, 32'd8, 1'b1, 1'b0);
    run = 1'b1;
    tick(); chk_if("halt", BUBBLE, 32'd8, 1'b0, 1'b1);
    tick(); chk_if("halt.hold", BUBBLE, 32'd8, 1'b0, 1'b1);
    run = 1'b0;
    tick(); chk_if("halt.idle", BUBBLE, 32'd8, 1'b0, 1'b0);

    // restore imem[2], rerun from 0: pc was reset to 0 on start
    wr(2, WC);
    run = 1'b1; tick(); run = 1'b0;
    tick(); chk_if("again.A", WA, 32'd4, 1'b1, 1'b0);
    tick(); chk_if("again.B", WB, 32'd8, 1'b1, 1'b0);
    tick(); chk_if("again.C", WC, 32'd12, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have parameter IMEM_DEPTH_LOG2, default 6, giving the log2 of the instruction memory depth in 32-bit words.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port imem_we, input, 1 bit: program-load write enable.
REQ-005 The module SHALL have port imem_waddr, input, IMEM_DEPTH_LOG2 bits: program-load word address.
REQ-006 The module SHALL have port imem_wdata, input, 32 bits: program-load data.
REQ-007 The module SHALL have port run, input, 1 bit: start/continue request.
REQ-008 The module SHALL have port stall, input, 1 bit: hold the PC and the IF/ID register.
REQ-009 The module SHALL have port branch_s3, input, 1 bit: taken-branch redirect.
REQ-010 The module SHALL have port branch_target_s3, input, 32 bits: redirect byte address.
REQ-011 The module SHALL have port instruction_s1, output, 32 bits: registered instruction to decode.
REQ-012 The module SHALL have port pc_out1_s1, output, 32 bits: registered PC+4 of instruction_s1.
REQ-013 The module SHALL have port busy, output, 1 bit: high in state RUN.
REQ-014 The module SHALL have port halted, output, 1 bit: high in state HALT.

Function
REQ-015 The module SHALL use states IDLE, RUN and HALT, held in a registered state machine.
REQ-016 The bubble word SHALL be 32'h0800_0000 (opcode 6'b000010: no register write, no memory access).
REQ-017 In IDLE, with imem_we=1, the module SHALL write imem[imem_waddr] <= imem_wdata; in RUN and HALT, imem_we SHALL be ignored.
REQ-018 On IDLE with run=1, the state SHALL go to RUN and pc SHALL be set to 0; a write in that same cycle SHALL still complete.
REQ-019 In RUN, the fetch index SHALL be pc[IMEM_DEPTH_LOG2+1:2], so the index wraps modulo the memory depth; pc itself SHALL wrap at 2^32.
REQ-020 In RUN, when stall=0 and branch_s3=0 and the fetched opcode is not 6'b111111, the module SHALL set instruction_s1 <= imem[index], pc_out1_s1 <= pc+4 and pc <= pc+4.
REQ-021 Latency SHALL be as follows: run sampled at edge N gives RUN from edge N; instruction_s1 SHALL equal imem[0] with pc_out1_s1=4 after edge N+1.
REQ-022 In RUN, when stall=1 and branch_s3=0, pc, instruction_s1 and pc_out1_s1 SHALL hold.
REQ-023 In RUN, branch_s3=1 SHALL have priority over stall and halt detection, and SHALL set pc <= {branch_target_s3[31:2],2'b00}; IF/ID behaviour is set by REQ-032 and REQ-033.
REQ-024 In RUN, when stall=0, branch_s3=0 and the fetched opcode is 6'b111111, the state SHALL go to HALT, instruction_s1 SHALL become the bubble, and pc SHALL hold (pointing at the halt word).
REQ-025 In HALT, the outputs SHALL hold, and the state SHALL go to IDLE when run=0.
REQ-026 In IDLE, instruction_s1 SHALL be the bubble and pc SHALL hold.
REQ-027 busy and halted SHALL be decoded from the registered state, with no combinational path from the inputs.

Reset
REQ-028 On reset=1 at a clock edge, the state SHALL become IDLE, pc=0, instruction_s1 = bubble, pc_out1_s1=0, busy=0 and halted=0.
REQ-029 Reset SHALL take priority over all other inputs, including mid-RUN, mid-stall and a concurrent branch.
REQ-030 imem contents SHALL NOT be cleared by reset.

Configuration
REQ-031 The macro IF_BRANCH_FLUSH_EN SHALL select the branch behaviour of the IF/ID register.
REQ-032 With IF_BRANCH_FLUSH_EN defined, a taken branch SHALL set instruction_s1 <= bubble and pc_out1_s1 <= the aligned target.
REQ-033 Without IF_BRANCH_FLUSH_EN, a taken branch SHALL set instruction_s1 <= imem[current index] and pc_out1_s1 <= pc+4 (delay-slot behaviour), with the halt opcode in that slot ignored.

Verification
REQ-034 Load imem[0..3]=A,B,C,D in IDLE, pulse run -> instruction_s1 sequence A,B,C,D with pc_out1_s1 = 4,8,12,16 on consecutive cycles, busy=1.
REQ-035 Assert stall for 2 cycles while B is on instruction_s1 -> B and pc_out1_s1=8 held for 2 extra cycles, then C follows.
REQ-036 Apply branch_s3=1 with target 32'h0000_0012 and stall=1 together -> pc=0x10; flush build gives a bubble then imem[4]; non-flush build gives the current word then imem[4].
REQ-037 Place 32'hFC00_0000 at imem[2] -> after B: bubble, halted=1, busy=0; run=0 -> IDLE; imem_we during RUN leaves memory unchanged.
REQ-038 Assert reset mid-RUN with a concurrent branch -> next cycle IDLE, pc=0, instruction_s1=32'h0800_0000, pc_out1_s1=0; program reruns from imem[0] on run.
REQ-039 Drive a PC beyond 4*2^IMEM_DEPTH_LOG2 (branch to 0x100 with depth 64) -> instruction_s1 = imem[0], pc_out1_s1=0x104.
